// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x3 keypad, debounces one key and presents it as clean row/column levels plus a code strobe.
// Latency: press accepted after the capture sample plus DEBOUNCE_SCANS matching samples (plus 2 sync clocks).
// Backpressure: none; key_valid is a one-clock strobe and key_code holds until the next accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] col_in,
    output logic [3:0] row_drive,
    output logic       row1,
    output logic       row2,
    output logic       row3,
    output logic       row4,
    output logic       col1,
    output logic       col2,
    output logic       col3,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        col_meta, col_sync;
    logic [CNT_W-1:0]  slot_cnt;
    logic              sample;
    logic              single;
    logic [3:0]        row_drive_q, row_drive_d, row_rot;
    logic [2:0]        cap_col_q, cap_col_d;
    logic [DB_W-1:0]   match_q, match_d, match_inc;
    logic [DB_W-1:0]   rel_q, rel_d, rel_inc;
    logic              key_valid_q, key_valid_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_held_q, key_held_d;
    logic [3:0]        row_lvl_q, row_lvl_d;
    logic [2:0]        col_lvl_q, col_lvl_d;

    // Map the frozen row and captured column (both one-hot) to the key code.
    function automatic logic [3:0] encode(input logic [3:0] row_oh, input logic [2:0] col_oh);
        logic [3:0] code;
        code = 4'h0;
        case ({row_oh, col_oh})
            7'b0001_001: code = 4'h1;
            7'b0001_010: code = 4'h2;
            7'b0001_100: code = 4'h3;
            7'b0010_001: code = 4'h4;
            7'b0010_010: code = 4'h5;
            7'b0010_100: code = 4'h6;
            7'b0100_001: code = 4'h7;
            7'b0100_010: code = 4'h8;
            7'b0100_100: code = 4'h9;
            7'b1000_001: code = 4'hA;
            7'b1000_010: code = 4'h0;
            7'b1000_100: code = 4'hB;
            default:     code = 4'h0;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer; the raw columns are never used directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_meta <= 3'b000;
            col_sync <= 3'b000;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    // Free-running slot counter; the last clock of each slot is the sample point.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
        end else if (slot_cnt == CNT_W'(SCAN_DIV - 1)) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    assign sample    = (slot_cnt == CNT_W'(SCAN_DIV - 1));
    assign single    = (col_sync == 3'b001) || (col_sync == 3'b010) || (col_sync == 3'b100);
    assign row_rot   = {row_drive_q[2:0], row_drive_q[3]};
    assign match_inc = match_q + DB_W'(1);
    assign rel_inc   = rel_q + DB_W'(1);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers, so every output to the safe comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_drive_q <= 4'b0001;
            cap_col_q   <= 3'b000;
            match_q     <= '0;
            rel_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
            row_lvl_q   <= 4'b0000;
            col_lvl_q   <= 3'b000;
        end else begin
            row_drive_q <= row_drive_d;
            cap_col_q   <= cap_col_d;
            match_q     <= match_d;
            rel_q       <= rel_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            row_lvl_q   <= row_lvl_d;
            col_lvl_q   <= col_lvl_d;
        end
    end

    // Next-state and next-output logic; all decisions are taken only at the sample point.
    always_comb begin
        state_d     = state_q;
        row_drive_d = row_drive_q;
        cap_col_d   = cap_col_q;
        match_d     = match_q;
        rel_d       = rel_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        row_lvl_d   = row_lvl_q;
        col_lvl_d   = col_lvl_q;
        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (single) begin
                        // Freeze on this row and remember which column fired.
                        cap_col_d = col_sync;
                        match_d   = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        row_drive_d = row_rot;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    // cap_col_q is one-hot, so equality also implies a single column.
                    if (col_sync == cap_col_q) begin
                        if (match_inc == DB_W'(DEBOUNCE_SCANS)) begin
                            state_d     = HELD;
                            match_d     = '0;
                            rel_d       = '0;
                            key_valid_d = 1'b1;
                            key_code_d  = encode(row_drive_q, cap_col_q);
                            key_held_d  = 1'b1;
                            row_lvl_d   = row_drive_q;
                            col_lvl_d   = cap_col_q;
                        end else begin
                            match_d = match_inc;
                        end
                    end else begin
                        state_d     = SCAN;
                        row_drive_d = row_rot;
                    end
                end
            end
            HELD: begin
                if (sample) begin
                    // Any column high, even a different one, restarts the release count.
                    if (col_sync == 3'b000) begin
                        if (rel_inc == DB_W'(DEBOUNCE_SCANS)) begin
                            state_d     = SCAN;
                            rel_d       = '0;
                            key_held_d  = 1'b0;
                            row_lvl_d   = 4'b0000;
                            col_lvl_d   = 3'b000;
                            row_drive_d = row_rot;
                        end else begin
                            rel_d = rel_inc;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    assign row_drive = row_drive_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign row1      = row_lvl_q[0];
    assign row2      = row_lvl_q[1];
    assign row3      = row_lvl_q[2];
    assign row4      = row_lvl_q[3];
    assign col1      = col_lvl_q[0];
    assign col2      = col_lvl_q[1];
    assign col3      = col_lvl_q[2];

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: randomized and directed stimulus on a modelled keypad, compared cycle by cycle with a per-sample reference.
// Latency: reference steps once per scan slot; outputs are compared one time unit after every rising edge.
// Backpressure: none.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk;
    logic       reset_n;
    logic [2:0] col_in;
    logic [3:0] row_drive;
    logic       row1, row2, row3, row4;
    logic       col1, col2, col3;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    // Physical keypad: bit r*3+c is the key at row r, column c.
    logic [11:0] keys;

    int n_checks;
    int n_fail;
    int seen_valid;

    // Reference model state, one step per sample point.
    int         m_mode;   // 0 scanning, 1 debouncing, 2 held
    int         m_row;
    int         m_col;
    int         m_match;
    int         m_rel;
    logic [3:0] m_code;
    logic       m_valid;

    int key_tbl[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    logic [16:0] dut_vec;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .col_in    (col_in),
        .row_drive (row_drive),
        .row1      (row1),
        .row2      (row2),
        .row3      (row3),
        .row4      (row4),
        .col1      (col1),
        .col2      (col2),
        .col3      (col3),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    // A column reads high when any pressed key on a driven row sits in it.
    assign col_in[0] = |(row_drive & {keys[9],  keys[6], keys[3], keys[0]});
    assign col_in[1] = |(row_drive & {keys[10], keys[7], keys[4], keys[1]});
    assign col_in[2] = |(row_drive & {keys[11], keys[8], keys[5], keys[2]});

    assign dut_vec = {row_drive, key_valid, key_code, key_held,
                      row4, row3, row2, row1, col3, col2, col1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] exp_vec();
        logic [3:0] rd;
        logic [3:0] rl;
        logic [2:0] cl;
        rd = 4'(1 << m_row);
        rl = (m_mode == 2) ? rd : 4'b0000;
        cl = (m_mode == 2) ? 3'(1 << m_col) : 3'b000;
        return {rd, m_valid, m_code, (m_mode == 2), rl, cl};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_row   = 0;
        m_col   = 0;
        m_match = 0;
        m_rel   = 0;
        m_code  = 4'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        int pat;
        int ones;
        int idx;
        pat  = 0;
        ones = 0;
        idx  = 0;
        for (int c = 0; c < 3; c++) begin
            if (keys[m_row * 3 + c]) begin
                pat  = pat | (1 << c);
                ones = ones + 1;
                idx  = c;
            end
        end
        m_valid = 1'b0;
        if (m_mode == 0) begin
            if (ones == 1) begin
                m_col   = idx;
                m_match = 0;
                m_mode  = 1;
            end else begin
                m_row = (m_row + 1) % 4;
            end
        end else if (m_mode == 1) begin
            if (ones == 1 && idx == m_col) begin
                m_match = m_match + 1;
                if (m_match == DB) begin
                    m_mode  = 2;
                    m_rel   = 0;
                    m_valid = 1'b1;
                    m_code  = 4'(key_tbl[m_row * 3 + m_col]);
                end
            end else begin
                m_mode = 0;
                m_row  = (m_row + 1) % 4;
            end
        end else begin
            if (pat == 0) begin
                m_rel = m_rel + 1;
                if (m_rel == DB) begin
                    m_mode = 0;
                    m_row  = (m_row + 1) % 4;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    // One scan slot: three quiet clocks, then the sample clock where the model steps.
    task automatic run_slot();
        m_valid = 1'b0;
        for (int i = 0; i < SD; i++) begin
            @(posedge clk);
            #1;
            if (i == SD - 1) model_step();
            if (key_valid) seen_valid++;
            check("outputs", 32'(dut_vec), 32'(exp_vec()));
        end
    endtask

    task automatic run_slots(input int n);
        for (int i = 0; i < n; i++) run_slot();
    endtask

    // Asynchronous reset pulse taken between clock edges; released just after an edge.
    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 32'(dut_vec), 32'(17'b0001_0_0000_0_0000_000));
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 32'(dut_vec), 32'(17'b0001_0_0000_0_0000_000));
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        seen_valid = 0;
        keys       = 12'h000;
        reset_n    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(dut_vec), 32'(17'b0001_0_0000_0_0000_000));
        reset_n = 1'b1;

        // Idle scanning, no keys.
        run_slots(8);
        check("idle_no_valid", 32'(seen_valid), 32'd0);

        // Clean press of '5'.
        seen_valid = 0;
        keys = 12'(1 << 4);
        run_slots(12);
        check("k5_code", 32'(key_code), 32'h5);
        check("k5_held", 32'({key_held, row2, col2}), 32'b111);
        keys = 12'h000;
        run_slots(6);
        check("k5_once", 32'(seen_valid), 32'd1);

        // '5' bouncing on its second debounce sample.
        seen_valid = 0;
        keys = 12'(1 << 4);
        for (int i = 0; i < 8 && m_mode != 1; i++) run_slot();
        run_slot();
        keys = 12'h000;
        run_slot();
        check("bounce_row", 32'(row_drive), 32'b0100);
        check("bounce_no_valid", 32'(seen_valid), 32'd0);
        keys = 12'(1 << 4);
        run_slots(12);
        keys = 12'h000;
        run_slots(6);
        check("bounce_retry_once", 32'(seen_valid), 32'd1);

        // '#' held for 50 samples.
        seen_valid = 0;
        keys = 12'(1 << 11);
        run_slots(50);
        check("hash_code", 32'(key_code), 32'hB);
        check("hash_lines", 32'({row4, col3}), 32'b11);
        keys = 12'h000;
        run_slots(6);
        check("hash_once", 32'(seen_valid), 32'd1);

        // Two columns on row1: ignored.
        seen_valid = 0;
        keys = 12'b000_000_000_011;
        run_slots(12);
        check("multi_ignored", 32'(seen_valid), 32'd0);
        keys = 12'h000;
        run_slots(2);

        // Reset while '0' is held, key stays down across reset.
        keys = 12'(1 << 10);
        for (int i = 0; i < 20 && !key_held; i++) run_slot();
        check("k0_reach_held", 32'(key_held), 32'd1);
        run_slots(2);
        seen_valid = 0;
        pulse_reset();
        run_slots(12);
        check("k0_reaccept", 32'(seen_valid), 32'd1);
        check("k0_code", 32'(key_code), 32'h0);
        keys = 12'h000;
        run_slots(6);

        // Random key activity: single keys, ghost patterns, silence, occasional reset.
        for (int seg = 0; seg < 40; seg++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 65)      keys = 12'(1 << $urandom_range(0, 11));
            else if (r < 80) keys = 12'($urandom);
            else             keys = 12'h000;
            run_slots(int'($urandom_range(1, 10)));
            if ($urandom_range(0, 19) == 0) pulse_reset();
        end
        keys = 12'h000;
        run_slots(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
